// File: rtl/ysyx_24100006_axi_rd_arbiter.sv
// ysyx_24100006_axi_rd_arbiter
//
// Shares one downstream AXI-Lite read port between the instruction fetch
// unit (master 0) and the load/store unit (master 1). Only one read is in
// flight at a time. Simultaneous requests are resolved round-robin against
// the master that completed the previous read, so the LSU wins the first
// tie after reset.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   m0_* (IFU)           AR request in, AR ready out, R data/resp/valid out,
//                        R ready in
//   m1_* (LSU)           same shape as m0_*
//   s_*                  downstream AR (address/valid registered) and R
//                        channel towards the memory crossbar
//   grant                owner of the current transaction (0 IFU, 1 LSU)
//   busy                 high while a transaction is in flight

module ysyx_24100006_axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rvalid,
    input  logic              m0_rready,

    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rvalid,
    input  logic              m1_rready,

    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    output logic              s_rready,

    output logic              grant,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              grant_q;
    logic              grant_next;
    logic              last_grant;
    logic              last_next;
    logic [ADDR_W-1:0] araddr_q;
    logic [ADDR_W-1:0] araddr_next;
    logic              arvalid_q;
    logic              arvalid_next;
    logic              owner_rready;

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            grant_q    <= 1'b0;
            last_grant <= 1'b0;
            araddr_q   <= '0;
            arvalid_q  <= 1'b0;
        end else begin
            state      <= state_next;
            grant_q    <= grant_next;
            last_grant <= last_next;
            araddr_q   <= araddr_next;
            arvalid_q  <= arvalid_next;
        end
    end

    // The owner's R-channel ready is what the slave sees while in S_R.
    assign owner_rready = grant_q ? m1_rready : m0_rready;

    // Next-state logic and handshake steering towards the current owner.
    always_comb begin
        state_next   = state;
        grant_next   = grant_q;
        last_next    = last_grant;
        araddr_next  = araddr_q;
        arvalid_next = arvalid_q;
        m0_arready   = 1'b0;
        m1_arready   = 1'b0;
        m0_rvalid    = 1'b0;
        m1_rvalid    = 1'b0;
        s_rready     = 1'b0;

        case (state)
            S_IDLE: begin
                if (m0_arvalid || m1_arvalid) begin
                    // A tie goes to whichever master did not win last time.
                    grant_next   = (m0_arvalid && m1_arvalid) ? ~last_grant : m1_arvalid;
                    araddr_next  = grant_next ? m1_araddr : m0_araddr;
                    arvalid_next = 1'b1;
                    state_next   = S_AR;
                end
            end
            S_AR: begin
                m0_arready = ~grant_q & s_arready;
                m1_arready = grant_q & s_arready;
                if (arvalid_q && s_arready) begin
                    arvalid_next = 1'b0;
                    state_next   = S_R;
                end
            end
            S_R: begin
                s_rready  = owner_rready;
                m0_rvalid = ~grant_q & s_rvalid;
                m1_rvalid = grant_q & s_rvalid;
                if (s_rvalid && owner_rready) begin
                    last_next  = grant_q;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Read data and response fan out to both masters; only rvalid is steered.
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign m0_rresp  = s_rresp;
    assign m1_rresp  = s_rresp;

    assign s_araddr  = araddr_q;
    assign s_arvalid = arvalid_q;
    assign grant     = grant_q;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_ysyx_24100006_axi_rd_arbiter.sv
// tb_ysyx_24100006_axi_rd_arbiter
//
// Bench for the two-master read arbiter. A driver process models both
// masters (request queues) and the downstream slave (configurable or random
// latencies and data). The slave pushes each response it will return into a
// scoreboard queue; a monitor process keeps a transaction-level reference
// (who owns the port, which phase it is in, who won last) and checks every
// cycle, popping the scoreboard on each R handshake. Directed phases then
// compare the logged downstream grants/addresses against fixed values.

`timescale 1ns/1ps

module tb_ysyx_24100006_axi_rd_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] m0_araddr;
    logic        m0_arvalid;
    logic        m0_arready;
    logic [31:0] m0_rdata;
    logic [1:0]  m0_rresp;
    logic        m0_rvalid;
    logic        m0_rready;
    logic [31:0] m1_araddr;
    logic        m1_arvalid;
    logic        m1_arready;
    logic [31:0] m1_rdata;
    logic [1:0]  m1_rresp;
    logic        m1_rvalid;
    logic        m1_rready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic        grant;
    logic        busy;

    ysyx_24100006_axi_rd_arbiter #(
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_araddr  (m0_araddr),
        .m0_arvalid (m0_arvalid),
        .m0_arready (m0_arready),
        .m0_rdata   (m0_rdata),
        .m0_rresp   (m0_rresp),
        .m0_rvalid  (m0_rvalid),
        .m0_rready  (m0_rready),
        .m1_araddr  (m1_araddr),
        .m1_arvalid (m1_arvalid),
        .m1_arready (m1_arready),
        .m1_rdata   (m1_rdata),
        .m1_rresp   (m1_rresp),
        .m1_rvalid  (m1_rvalid),
        .m1_rready  (m1_rready),
        .s_araddr   (s_araddr),
        .s_arvalid  (s_arvalid),
        .s_arready  (s_arready),
        .s_rdata    (s_rdata),
        .s_rresp    (s_rresp),
        .s_rvalid   (s_rvalid),
        .s_rready   (s_rready),
        .grant      (grant),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Stimulus knobs
    bit          rand_mode = 0;
    bit          scramble  = 0;
    int          ar_wait   = 0;
    int          r_wait    = 0;
    int          rready_hold = 0;
    logic [31:0] fix_data  = 32'hDEADBEEF;
    logic [1:0]  fix_resp  = 2'b00;

    // Master request queues and response scoreboard
    logic [31:0] mq0[$];
    logic [31:0] mq1[$];
    logic [31:0] exp_data[$];
    logic [1:0]  exp_resp[$];

    // Transaction-level reference state
    bit          m_busy = 0;
    bit          m_phase_r = 0;
    bit          m_win = 0;
    bit          m_last = 0;
    logic [31:0] m_addr = 0;
    bit          chk_rst = 0;

    // Observed downstream AR handshakes and last delivered response
    bit          dut_win_log[$];
    logic [31:0] dut_addr_log[$];
    logic [31:0] obs_rdata = 0;
    logic [1:0]  obs_rresp = 0;
    bit          obs_who = 0;
    int          r_count = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input bit who, input logic [31:0] addr);
        if (who) mq1.push_back(addr);
        else     mq0.push_back(addr);
    endtask

    task automatic check_log(input string name, input int idx, input bit win, input logic [31:0] addr);
        if (idx < dut_win_log.size()) begin
            check_output({name, "_grant"}, 32'(dut_win_log[idx]), 32'(win));
            check_output({name, "_addr"}, dut_addr_log[idx], addr);
        end else begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL %s: only %0d AR handshakes seen, expected entry %0d", name, dut_win_log.size(), idx);
        end
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while ((mq0.size() != 0 || mq1.size() != 0 || m_busy) && c < budget) begin
            @(posedge clk);
            c++;
        end
        #2;
        if (c >= budget) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL drain_timeout: still busy after %0d cycles, expected idle", c);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    // Driver: masters and slave. Handshakes are sampled mid-cycle and the
    // inputs for the next cycle are driven just after the rising edge.
    initial begin : driver
        int ar_seen;
        int r_seen;
        int rv_seen;
        bit pend;
        bit rst, fa0, fa1, fas, frs, sav, srv;
        logic [31:0] cur_data;
        logic [1:0]  cur_resp;
        ar_seen = 0; r_seen = 0; rv_seen = 0; pend = 0;
        cur_data = 0; cur_resp = 0;
        m0_araddr = 0; m0_arvalid = 0; m0_rready = 0;
        m1_araddr = 0; m1_arvalid = 0; m1_rready = 0;
        s_arready = 0; s_rdata = 0; s_rresp = 0; s_rvalid = 0;
        forever begin
            @(negedge clk);
            rst = reset;
            fa0 = m0_arvalid & m0_arready;
            fa1 = m1_arvalid & m1_arready;
            fas = s_arvalid & s_arready;
            frs = s_rvalid & s_rready;
            sav = s_arvalid;
            srv = s_rvalid;
            @(posedge clk);
            #1;
            if (rst) begin
                pend = 0; ar_seen = 0; r_seen = 0; rv_seen = 0;
            end else begin
                if (fa0 && mq0.size() != 0) void'(mq0.pop_front());
                if (fa1 && mq1.size() != 0) void'(mq1.pop_front());
                if (fas) begin
                    ar_seen = 0; r_seen = 0; rv_seen = 0; pend = 1;
                    cur_data = rand_mode ? $urandom : fix_data;
                    cur_resp = rand_mode ? 2'($urandom_range(0, 3)) : fix_resp;
                    exp_data.push_back(cur_data);
                    exp_resp.push_back(cur_resp);
                    if (rand_mode) begin
                        ar_wait = $urandom_range(0, 3);
                        r_wait  = $urandom_range(0, 3);
                    end
                end else if (sav) begin
                    ar_seen++;
                end
                if (frs) begin
                    pend = 0; rv_seen = 0;
                end else if (pend && srv) begin
                    rv_seen++;
                end else if (pend) begin
                    r_seen++;
                end
            end
            s_arready = (ar_seen >= ar_wait);
            s_rvalid  = pend && (r_seen >= r_wait);
            if (pend) begin
                s_rdata = cur_data;
                s_rresp = cur_resp;
            end else begin
                s_rdata = $urandom;
                s_rresp = 2'($urandom_range(0, 3));
            end
            m0_rready  = rand_mode ? ($urandom_range(0, 3) != 0) : (rv_seen >= rready_hold);
            m1_rready  = rand_mode ? ($urandom_range(0, 3) != 0) : (rv_seen >= rready_hold);
            m0_arvalid = (mq0.size() != 0);
            m1_arvalid = (mq1.size() != 0);
            m0_araddr  = (mq0.size() != 0) ? mq0[0] : $urandom;
            m1_araddr  = (mq1.size() != 0) ? mq1[0] : $urandom;
            // Granted master wanders off its address while waiting for arready.
            if (scramble && m_busy && !m_phase_r) begin
                if (m_win) m1_araddr = m1_araddr ^ 32'h0000_0100;
                else       m0_araddr = m0_araddr ^ 32'h0000_0100;
            end
        end
    end

    // Monitor and reference model, evaluated mid-cycle.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset) begin
                m_busy = 0; m_phase_r = 0; m_last = 0;
                exp_data.delete();
                exp_resp.delete();
                chk_rst = 1;
            end else begin
                if (chk_rst) begin
                    check_output("rst_busy", 32'(busy), 32'd0);
                    check_output("rst_grant", 32'(grant), 32'd0);
                    check_output("rst_s_arvalid", 32'(s_arvalid), 32'd0);
                    check_output("rst_s_araddr", s_araddr, 32'd0);
                    check_output("rst_s_rready", 32'(s_rready), 32'd0);
                    check_output("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
                    check_output("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
                    chk_rst = 0;
                end
                if (s_rvalid && s_rready) r_count++;
                check_output("busy", 32'(busy), 32'(m_busy));
                check_output("fanout_rdata0", m0_rdata, s_rdata);
                check_output("fanout_rdata1", m1_rdata, s_rdata);
                check_output("fanout_rresp0", 32'(m0_rresp), 32'(s_rresp));
                check_output("fanout_rresp1", 32'(m1_rresp), 32'(s_rresp));
                if (!m_busy) begin
                    check_output("idle_s_arvalid", 32'(s_arvalid), 32'd0);
                    check_output("idle_m0_arready", 32'(m0_arready), 32'd0);
                    check_output("idle_m1_arready", 32'(m1_arready), 32'd0);
                    check_output("idle_m0_rvalid", 32'(m0_rvalid), 32'd0);
                    check_output("idle_m1_rvalid", 32'(m1_rvalid), 32'd0);
                    check_output("idle_s_rready", 32'(s_rready), 32'd0);
                    if (m0_arvalid || m1_arvalid) begin
                        m_win     = (m0_arvalid && m1_arvalid) ? !m_last : m1_arvalid;
                        m_addr    = m_win ? m1_araddr : m0_araddr;
                        m_busy    = 1;
                        m_phase_r = 0;
                    end
                end else if (!m_phase_r) begin
                    check_output("ar_grant", 32'(grant), 32'(m_win));
                    check_output("ar_s_arvalid", 32'(s_arvalid), 32'd1);
                    check_output("ar_s_araddr", s_araddr, m_addr);
                    check_output("ar_owner_arready", 32'(m_win ? m1_arready : m0_arready), 32'(s_arready));
                    check_output("ar_other_arready", 32'(m_win ? m0_arready : m1_arready), 32'd0);
                    check_output("ar_m0_rvalid", 32'(m0_rvalid), 32'd0);
                    check_output("ar_m1_rvalid", 32'(m1_rvalid), 32'd0);
                    check_output("ar_s_rready", 32'(s_rready), 32'd0);
                    if (s_arvalid && s_arready) begin
                        dut_win_log.push_back(grant);
                        dut_addr_log.push_back(s_araddr);
                        m_phase_r = 1;
                    end
                end else begin
                    check_output("r_grant", 32'(grant), 32'(m_win));
                    check_output("r_s_arvalid", 32'(s_arvalid), 32'd0);
                    check_output("r_m0_arready", 32'(m0_arready), 32'd0);
                    check_output("r_m1_arready", 32'(m1_arready), 32'd0);
                    check_output("r_owner_rvalid", 32'(m_win ? m1_rvalid : m0_rvalid), 32'(s_rvalid));
                    check_output("r_other_rvalid", 32'(m_win ? m0_rvalid : m1_rvalid), 32'd0);
                    check_output("r_s_rready", 32'(s_rready), 32'(m_win ? m1_rready : m0_rready));
                    if (s_rvalid && s_rready) begin
                        if (exp_data.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("[TB] FAIL r_scoreboard: R handshake with no expected response queued");
                        end else begin
                            check_output("sb_rdata", m_win ? m1_rdata : m0_rdata, exp_data.pop_front());
                            check_output("sb_rresp", 32'(m_win ? m1_rresp : m0_rresp), 32'(exp_resp.pop_front()));
                        end
                        obs_rdata = m_win ? m1_rdata : m0_rdata;
                        obs_rresp = m_win ? m1_rresp : m0_rresp;
                        obs_who   = m1_rvalid;
                        m_busy    = 0;
                        m_last    = m_win;
                    end
                end
            end
        end
    end

    initial begin : main
        int c;
        int r_before;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Single IFU read with an immediate slave
        $display("[TB] single IFU read");
        dut_win_log.delete(); dut_addr_log.delete();
        apply_stimulus(0, 32'h3000_0000);
        wait_done(200);
        check_log("ifu", 0, 0, 32'h3000_0000);
        check_output("ifu_rdata", obs_rdata, 32'hDEADBEEF);
        check_output("ifu_owner", 32'(obs_who), 32'd0);

        // Tie right after reset: LSU first, then strict alternation
        $display("[TB] tie after reset");
        do_reset();
        dut_win_log.delete(); dut_addr_log.delete();
        apply_stimulus(0, 32'h100); apply_stimulus(0, 32'h100);
        apply_stimulus(1, 32'h200); apply_stimulus(1, 32'h200);
        wait_done(300);
        check_log("tie0", 0, 1, 32'h200);
        check_log("tie1", 1, 0, 32'h100);
        check_log("tie2", 2, 1, 32'h200);
        check_log("tie3", 3, 0, 32'h100);

        // Slave AR backpressure and master R backpressure
        $display("[TB] backpressure");
        ar_wait = 5; rready_hold = 3;
        dut_win_log.delete(); dut_addr_log.delete();
        r_before = r_count;
        apply_stimulus(0, 32'h40);
        wait_done(300);
        check_log("bp", 0, 0, 32'h40);
        check_output("bp_ar_count", 32'(dut_win_log.size()), 32'd1);
        check_output("bp_r_count", 32'(r_count - r_before), 32'd1);
        check_output("bp_rdata", obs_rdata, 32'hDEADBEEF);

        // Granted LSU changes its address while waiting for arready
        $display("[TB] address change after grant");
        ar_wait = 3; rready_hold = 0; scramble = 1;
        dut_win_log.delete(); dut_addr_log.delete();
        apply_stimulus(1, 32'h200);
        wait_done(300);
        check_log("addr_hold", 0, 1, 32'h200);
        scramble = 0; ar_wait = 0;

        // Reset while waiting for read data
        $display("[TB] reset mid-transaction");
        r_wait = 10;
        apply_stimulus(0, 32'h500);
        c = 0;
        while (!(m_busy && m_phase_r) && c < 100) begin
            @(posedge clk);
            c++;
        end
        if (c >= 100) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL reach_r_phase: not in R phase after %0d cycles, expected R phase", c);
        end
        do_reset();
        r_wait = 0;
        dut_win_log.delete(); dut_addr_log.delete();
        apply_stimulus(0, 32'h100);
        apply_stimulus(1, 32'h200);
        wait_done(300);
        check_log("rst_tie0", 0, 1, 32'h200);
        check_log("rst_tie1", 1, 0, 32'h100);

        // Error response passes through untouched
        $display("[TB] error response");
        fix_resp = 2'b10;
        apply_stimulus(1, 32'h600);
        wait_done(300);
        check_output("err_rresp", 32'(obs_rresp), 32'd2);
        check_output("err_owner", 32'(obs_who), 32'd1);
        check_output("err_idle", 32'(busy), 32'd0);
        fix_resp = 2'b00;

        // Randomised traffic against the reference model
        $display("[TB] random traffic");
        rand_mode = 1; scramble = 1;
        for (int b = 0; b < 40; b++) begin
            int k0;
            int k1;
            k0 = $urandom_range(0, 3);
            k1 = $urandom_range(0, 3);
            for (int i = 0; i < k0; i++) apply_stimulus(0, $urandom & 32'hFFFF_FFFC);
            for (int i = 0; i < k1; i++) apply_stimulus(1, $urandom & 32'hFFFF_FFFC);
            wait_done(3000);
        end
        rand_mode = 0; scramble = 0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
